// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between two requesters:
//   m0 = CPU load/store unit, m1 = DMA/debug loader.
// A request seen in IDLE is arbitrated and latched. In the next cycle (ACCESS)
// the latched command drives the memory pins. The cycle after that (RESP)
// returns a one-cycle ack with the registered read data. Word addresses below
// 1024 are outside the populated window. They are acked with err and never
// reach the memory.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_req/we/addr/wdata       request side of master X (X = 0, 1)
//   mX_ack/err/rdata           response side of master X, valid in RESP only
//   mem_addr/wdata/write/read  memory command, non-zero only in ACCESS
//   mem_rdata                  combinational memory read data
//   conflict_cnt               saturating count of IDLE cycles with both reqs
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter bit FIXED_PRIO = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             m0_req,
   input  logic             m0_we,
   input  logic [10:0]      m0_addr,
   input  logic [31:0]      m0_wdata,
   output logic             m0_ack,
   output logic             m0_err,
   output logic [31:0]      m0_rdata,
   input  logic             m1_req,
   input  logic             m1_we,
   input  logic [10:0]      m1_addr,
   input  logic [31:0]      m1_wdata,
   output logic             m1_ack,
   output logic             m1_err,
   output logic [31:0]      m1_rdata,
   output logic [10:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             mem_write,
   output logic             mem_read,
   input  logic [31:0]      mem_rdata,
   output logic [CNT_W-1:0] conflict_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_state_next;
   logic              r_cmd_sel;
   logic              r_cmd_we;
   logic [10:0]       r_cmd_addr;
   logic [31:0]       r_cmd_wdata;
   logic              r_cmd_err;
   logic              r_last_sel;
   logic [31:0]       r_rdata_q;
   logic [CNT_W-1:0]  r_conflict_cnt;

   logic              w_grant_m1;
   logic              w_sel_we;
   logic [10:0]       w_sel_addr;
   logic [31:0]       w_sel_wdata;

   // On a tie, round-robin picks the master that did not win last time.
   // r_last_sel resets to 1, so m0 wins the first tie.
   always_comb begin
      if (m0_req && m1_req)
         w_grant_m1 = FIXED_PRIO ? 1'b0 : ~r_last_sel;
      else
         w_grant_m1 = m1_req;
   end

   assign w_sel_we    = w_grant_m1 ? m1_we    : m0_we;
   assign w_sel_addr  = w_grant_m1 ? m1_addr  : m0_addr;
   assign w_sel_wdata = w_grant_m1 ? m1_wdata : m0_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   // Next state and all outputs. The memory pins and the responses are
   // decoded from the state, so they are zero outside their own cycle.
   always_comb begin
      w_state_next = r_state;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_write    = 1'b0;
      mem_read     = 1'b0;
      m0_ack       = 1'b0;
      m0_err       = 1'b0;
      m0_rdata     = '0;
      m1_ack       = 1'b0;
      m1_err       = 1'b0;
      m1_rdata     = '0;
      case (r_state)
         S_IDLE: begin
            if (m0_req || m1_req)
               w_state_next = S_ACCESS;
         end
         S_ACCESS: begin
            mem_addr     = r_cmd_addr;
            mem_wdata    = r_cmd_wdata;
            mem_write    = r_cmd_we & ~r_cmd_err;
            mem_read     = ~r_cmd_we & ~r_cmd_err;
            w_state_next = S_RESP;
         end
         S_RESP: begin
            if (r_cmd_sel) begin
               m1_ack   = 1'b1;
               m1_err   = r_cmd_err;
               m1_rdata = r_rdata_q;
            end else begin
               m0_ack   = 1'b1;
               m0_err   = r_cmd_err;
               m0_rdata = r_rdata_q;
            end
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_sel      <= 1'b0;
         r_cmd_we       <= 1'b0;
         r_cmd_addr     <= '0;
         r_cmd_wdata    <= '0;
         r_cmd_err      <= 1'b0;
         r_last_sel     <= 1'b1;
         r_rdata_q      <= '0;
         r_conflict_cnt <= '0;
      end else begin
         if (r_state == S_IDLE && m0_req && m1_req && r_conflict_cnt != '1)
            r_conflict_cnt <= r_conflict_cnt + CNT_ONE;
         if (r_state == S_IDLE && (m0_req || m1_req)) begin
            r_cmd_sel   <= w_grant_m1;
            r_last_sel  <= w_grant_m1;
            r_cmd_we    <= w_sel_we;
            r_cmd_addr  <= w_sel_addr;
            r_cmd_wdata <= w_sel_wdata;
            r_cmd_err   <= ~w_sel_addr[10];
         end
         // mem_rdata is only meaningful while mem_read is high. Writes and
         // rejected commands therefore return zero data.
         if (r_state == S_ACCESS)
            r_rdata_q <= (r_cmd_err || r_cmd_we) ? 32'h0 : mem_rdata;
      end
   end

   assign conflict_cnt = r_conflict_cnt;

endmodule
